// File: rtl/wasm_value_stack_if.sv
// Operand-stack port bundle: op request from the core and stack status back.
// The core side uses master; the stack itself uses slave.
interface wasm_value_stack_if #(
    parameter int WIDTH      = 64,
    parameter int DEPTH_LOG2 = 4
);
    logic                  op_valid;
    logic [2:0]            op;
    logic [WIDTH-1:0]      push_data;
    logic                  ready;
    logic [WIDTH-1:0]      pop_data;
    logic                  pop_valid;
    logic [WIDTH-1:0]      top;
    logic                  empty;
    logic                  full;
    logic [DEPTH_LOG2:0]   count;
    logic [3:0]            trap;

    modport master (
        output op_valid, op, push_data,
        input  ready, pop_data, pop_valid, top, empty, full, count, trap
    );

    modport slave (
        input  op_valid, op, push_data,
        output ready, pop_data, pop_valid, top, empty, full, count, trap
    );
endinterface

// File: rtl/wasm_value_stack.sv
// WebAssembly operand stack: single-cycle push/pop/drop/dup/select with a
// registered top copy and sticky trap codes that freeze the stack until reset.
module wasm_value_stack #(
    parameter int WIDTH      = 64,
    parameter int DEPTH_LOG2 = 4,
    parameter int COND_WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    wasm_value_stack_if.slave bus
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    localparam logic [CW-1:0] CNT_0    = CW'(0);
    localparam logic [CW-1:0] CNT_1    = CW'(1);
    localparam logic [CW-1:0] CNT_2    = CW'(2);
    localparam logic [CW-1:0] CNT_3    = CW'(3);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_TRAPPED = 1'b1;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_PUSH   = 3'd1;
    localparam logic [2:0] OP_POP    = 3'd2;
    localparam logic [2:0] OP_DROP   = 3'd3;
    localparam logic [2:0] OP_DUP    = 3'd4;
    localparam logic [2:0] OP_SELECT = 3'd5;

    localparam logic [3:0] TRAP_NONE      = 4'd0;
    localparam logic [3:0] TRAP_UNDERFLOW = 4'd1;
    localparam logic [3:0] TRAP_OVERFLOW  = 4'd2;
    localparam logic [3:0] TRAP_INVALID   = 4'd3;

    logic [0:0]            state_q;
    logic [CW-1:0]         count_q;
    logic [WIDTH-1:0]      top_q;
    logic [WIDTH-1:0]      pop_data_q;
    logic                  pop_valid_q;
    logic [3:0]            trap_q;
    logic [WIDTH-1:0]      mem [DEPTH];

    logic                  is_empty;
    logic                  is_full;
    logic                  accept;
    logic                  exec;
    logic [3:0]            fault;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic [DEPTH_LOG2-1:0] idx_m2;
    logic [DEPTH_LOG2-1:0] idx_m3;
    logic [WIDTH-1:0]      entry_b;
    logic [WIDTH-1:0]      entry_a;
    logic [WIDTH-1:0]      sel_result;
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_waddr;
    logic [WIDTH-1:0]      mem_wdata;

    assign is_empty = (count_q == CNT_0);
    assign is_full  = (count_q == CNT_FULL);
    assign accept   = bus.op_valid && (state_q == ST_RUN);

    // The top entry lives in top_q, so only the two entries beneath it are read.
    assign wr_idx     = count_q[DEPTH_LOG2-1:0];
    assign idx_m2     = DEPTH_LOG2'(count_q - CNT_2);
    assign idx_m3     = DEPTH_LOG2'(count_q - CNT_3);
    assign entry_b    = mem[idx_m2];
    assign entry_a    = mem[idx_m3];
    assign sel_result = (top_q[COND_WIDTH-1:0] != '0) ? entry_a : entry_b;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        fault = TRAP_NONE;
        if (accept) begin
            case (bus.op)
                OP_NOP:           fault = TRAP_NONE;
                OP_PUSH:          if (is_full) fault = TRAP_OVERFLOW;
                OP_POP, OP_DROP:  if (is_empty) fault = TRAP_UNDERFLOW;
                OP_DUP: begin
                    if (is_empty)     fault = TRAP_UNDERFLOW;
                    else if (is_full) fault = TRAP_OVERFLOW;
                end
                OP_SELECT:        if (count_q < CNT_3) fault = TRAP_UNDERFLOW;
                default:          fault = TRAP_INVALID;
            endcase
        end
    end

    assign exec = accept && (fault == TRAP_NONE);

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_idx;
        mem_wdata = bus.push_data;
        if (exec) begin
            case (bus.op)
                OP_PUSH:   mem_we = 1'b1;
                OP_DUP: begin
                    mem_we    = 1'b1;
                    mem_wdata = top_q;
                end
                OP_SELECT: begin
                    mem_we    = 1'b1;
                    mem_waddr = idx_m3;
                    mem_wdata = sel_result;
                end
                default:   mem_we = 1'b0;
            endcase
        end
    end

    // NOTE: the entry array has no reset; count_q alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) mem[mem_waddr] <= mem_wdata;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            count_q     <= CNT_0;
            top_q       <= '0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
            trap_q      <= TRAP_NONE;
        end else begin
            pop_valid_q <= 1'b0;
            if (accept && fault != TRAP_NONE) begin
                trap_q  <= fault;
                state_q <= ST_TRAPPED;
            end else if (exec) begin
                case (bus.op)
                    OP_PUSH: begin
                        top_q   <= bus.push_data;
                        count_q <= count_q + CNT_1;
                    end
                    OP_POP: begin
                        pop_data_q  <= top_q;
                        pop_valid_q <= 1'b1;
                        top_q       <= (count_q == CNT_1) ? '0 : entry_b;
                        count_q     <= count_q - CNT_1;
                    end
                    OP_DROP: begin
                        top_q   <= (count_q == CNT_1) ? '0 : entry_b;
                        count_q <= count_q - CNT_1;
                    end
                    OP_DUP:    count_q <= count_q + CNT_1;
                    OP_SELECT: begin
                        top_q   <= sel_result;
                        count_q <= count_q - CNT_2;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.ready     = (state_q == ST_RUN);
    assign bus.pop_data  = pop_data_q;
    assign bus.pop_valid = pop_valid_q;
    assign bus.top       = top_q;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.count     = count_q;
    assign bus.trap      = trap_q;
endmodule

// File: tb/tb_wasm_value_stack.sv
// Directed bench for wasm_value_stack at default parameters (64-bit, 16 deep,
// 32-bit select condition); expected values are hand-computed constants.
module tb_wasm_value_stack;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    wasm_value_stack_if #(.WIDTH(64), .DEPTH_LOG2(4)) bus ();

    wasm_value_stack #(.WIDTH(64), .DEPTH_LOG2(4), .COND_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [2:0] o, input logic [63:0] d);
        @(negedge clk);
        bus.op_valid  = 1'b1;
        bus.op        = o;
        bus.push_data = d;
        @(posedge clk);
        #1;
        bus.op_valid  = 1'b0;
        bus.op        = 3'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        bus.op_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bus.op_valid  = 1'b0;
        bus.op        = 3'd0;
        bus.push_data = 64'd0;

        // Reset state
        do_reset();
        check("rst_count",     64'(bus.count), 64'd0);
        check("rst_empty",     64'(bus.empty), 64'd1);
        check("rst_full",      64'(bus.full), 64'd0);
        check("rst_top",       bus.top, 64'd0);
        check("rst_pop_data",  bus.pop_data, 64'd0);
        check("rst_pop_valid", 64'(bus.pop_valid), 64'd0);
        check("rst_trap",      64'(bus.trap), 64'd0);
        check("rst_ready",     64'(bus.ready), 64'd1);

        // SELECT with zero condition picks b
        do_op(3'd1, 64'd1);
        do_op(3'd1, 64'd2);
        do_op(3'd1, 64'd0);
        do_op(3'd5, 64'd0);
        check("sel0_top",   bus.top, 64'd2);
        check("sel0_count", 64'(bus.count), 64'd1);
        check("sel0_empty", 64'(bus.empty), 64'd0);
        check("sel0_trap",  64'(bus.trap), 64'd0);

        // SELECT with nonzero condition picks a
        do_reset();
        do_op(3'd1, 64'd1);
        do_op(3'd1, 64'd2);
        do_op(3'd1, 64'd7);
        do_op(3'd5, 64'd0);
        check("sel7_top",   bus.top, 64'd1);
        check("sel7_count", 64'(bus.count), 64'd1);

        // Upper condition bits are ignored
        do_reset();
        do_op(3'd1, 64'd5);
        do_op(3'd1, 64'd9);
        do_op(3'd1, 64'h1_0000_0000);
        do_op(3'd5, 64'd0);
        check("selhi_top",   bus.top, 64'd9);
        check("selhi_count", 64'(bus.count), 64'd1);

        // SELECT with two entries underflows and leaves the stack alone
        do_reset();
        do_op(3'd1, 64'd11);
        do_op(3'd1, 64'd12);
        do_op(3'd5, 64'd0);
        check("sel2_trap",  64'(bus.trap), 64'd1);
        check("sel2_count", 64'(bus.count), 64'd2);
        check("sel2_top",   bus.top, 64'd12);

        // Fill to capacity, then overflow
        do_reset();
        for (int i = 0; i < 16; i++) do_op(3'd1, 64'(100 + i));
        check("fill_full",  64'(bus.full), 64'd1);
        check("fill_count", 64'(bus.count), 64'd16);
        check("fill_top",   bus.top, 64'd115);
        do_op(3'd1, 64'hdead);
        check("ovf_trap",  64'(bus.trap), 64'd2);
        check("ovf_ready", 64'(bus.ready), 64'd0);
        check("ovf_top",   bus.top, 64'd115);
        check("ovf_count", 64'(bus.count), 64'd16);
        do_op(3'd6, 64'd0);
        do_op(3'd2, 64'd0);
        check("ovf_first_wins", 64'(bus.trap), 64'd2);
        check("ovf_frozen_cnt", 64'(bus.count), 64'd16);
        check("ovf_no_pop",     64'(bus.pop_valid), 64'd0);

        // DUP at full overflows
        do_reset();
        for (int i = 0; i < 16; i++) do_op(3'd1, 64'(i));
        do_op(3'd4, 64'd0);
        check("dupf_trap",  64'(bus.trap), 64'd2);
        check("dupf_count", 64'(bus.count), 64'd16);

        // POP at empty underflows; later ops ignored; reset clears
        do_reset();
        do_op(3'd2, 64'd0);
        check("unf_trap",      64'(bus.trap), 64'd1);
        check("unf_pop_valid", 64'(bus.pop_valid), 64'd0);
        do_op(3'd1, 64'd44);
        check("unf_ignored", 64'(bus.count), 64'd0);
        check("unf_top",     bus.top, 64'd0);
        do_reset();
        check("clr_trap",  64'(bus.trap), 64'd0);
        check("clr_ready", 64'(bus.ready), 64'd1);
        check("clr_empty", 64'(bus.empty), 64'd1);

        // DUP then two POPs, DROP, POP to empty
        do_op(3'd1, 64'd10);
        do_op(3'd1, 64'd20);
        do_op(3'd4, 64'd0);
        check("dup_count", 64'(bus.count), 64'd3);
        check("dup_top",   bus.top, 64'd20);
        do_op(3'd2, 64'd0);
        check("pop1_data",  bus.pop_data, 64'd20);
        check("pop1_valid", 64'(bus.pop_valid), 64'd1);
        @(posedge clk);
        #1;
        check("pop1_pulse_end", 64'(bus.pop_valid), 64'd0);
        do_op(3'd2, 64'd0);
        check("pop2_data",  bus.pop_data, 64'd20);
        check("pop2_valid", 64'(bus.pop_valid), 64'd1);
        check("pop2_top",   bus.top, 64'd10);
        check("pop2_count", 64'(bus.count), 64'd1);
        do_op(3'd1, 64'd33);
        do_op(3'd3, 64'd0);
        check("drop_top",       bus.top, 64'd10);
        check("drop_count",     64'(bus.count), 64'd1);
        check("drop_pop_data",  bus.pop_data, 64'd20);
        check("drop_pop_valid", 64'(bus.pop_valid), 64'd0);
        do_op(3'd2, 64'd0);
        check("pop3_data",  bus.pop_data, 64'd10);
        check("pop3_empty", 64'(bus.empty), 64'd1);
        check("pop3_top",   bus.top, 64'd0);

        // Reserved op traps; reset wins over a concurrent PUSH
        do_op(3'd6, 64'd0);
        check("inv_trap",  64'(bus.trap), 64'd3);
        check("inv_ready", 64'(bus.ready), 64'd0);
        @(negedge clk);
        reset         = 1'b1;
        bus.op_valid  = 1'b1;
        bus.op        = 3'd1;
        bus.push_data = 64'd77;
        @(posedge clk);
        #1;
        check("rstpush_count", 64'(bus.count), 64'd0);
        check("rstpush_top",   bus.top, 64'd0);
        check("rstpush_trap",  64'(bus.trap), 64'd0);
        @(negedge clk);
        reset        = 1'b0;
        bus.op_valid = 1'b0;
        bus.op       = 3'd0;
        @(posedge clk);
        #1;
        check("post_rst_empty", 64'(bus.empty), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wasm_value_stack.md
Name: wasm_value_stack

Overview:
- Parametrised WebAssembly operand stack for the cpu core. Replaces the fixed-size value stack.
- Width and depth are configurable.
- Executes push, pop, drop, dup (tee) and the wasm select operator as single-cycle ops.
- Exposes the top-of-stack and emptiness that drive the cpu result and result_empty outputs, and raises sticky trap codes on stack faults.

Parameters:
- WIDTH, 64, bit width of each stack entry.
- DEPTH_LOG2, 4, log2 of capacity; the stack holds 2**DEPTH_LOG2 entries.
- COND_WIDTH, 32, number of low bits of the condition operand examined by select (i32 semantics).

Ports:
- clk  input  1  system clock, all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- op_valid  input  1  op presented this cycle.
- op  input  3  operation code: 0 NOP, 1 PUSH, 2 POP, 3 DROP, 4 DUP, 5 SELECT, 6-7 reserved.
- push_data  input  WIDTH  operand for PUSH.
- ready  output  1  high when ops are accepted; low while trapped.
- pop_data  output  WIDTH  value removed by the last POP. Held until the next POP.
- pop_valid  output  1  one-cycle pulse the cycle after a successful POP.
- top  output  WIDTH  current top-of-stack entry. 0 when empty.
- empty  output  1  count == 0.
- full  output  1  count == 2**DEPTH_LOG2.
- count  output  DEPTH_LOG2+1  number of valid entries.
- trap  output  4  0 none, 1 stack underflow, 2 stack overflow, 3 invalid op. Sticky.

Behaviour:
- Reset (synchronous, active-high):
  - count=0, empty=1, full=0, top=0.
  - pop_data=0, pop_valid=0, trap=0, ready=1.
  - State -> RUN. Reset overrides any op in the same cycle, including mid-trap.
- Storage: register array indexed by count, plus a registered top copy. The array contents themselves need not be cleared on reset.
- States:
  - RUN: accepts ops when op_valid.
  - TRAPPED: ready=0, op_valid ignored, all outputs frozen. Exited only by reset.
- Ops are accepted when op_valid && ready. Effect is visible on top/count/empty/full the next cycle (latency 1). Back-to-back ops every cycle are supported.
- PUSH:
  - needs count < capacity, else trap=2;
  - new top = push_data; count+1.
- POP:
  - needs count >= 1, else trap=1;
  - pop_data = old top, pop_valid pulses for one cycle, count-1, top = next entry (0 if now empty).
- DROP: as POP, but pop_data and pop_valid are unaffected.
- DUP:
  - needs count >= 1 (else trap=1) and count < capacity (else trap=2);
  - pushes a copy of top.
- SELECT:
  - needs count >= 3, else trap=1;
  - c = entry[count-1], b = entry[count-2], a = entry[count-3];
  - result = (c[COND_WIDTH-1:0] != 0) ? a : b; only the low COND_WIDTH bits of c matter;
  - net count-2, top = result, completes in a single cycle.
- Reserved op codes 6-7 -> trap=3.
- NOP, or op_valid=0: no change.
- On any trap:
  - stack contents, count and top are unchanged by the faulting op;
  - trap latches its code and the state moves to TRAPPED on the same edge;
  - the first fault wins, later ones are ignored.
- Boundary cases:
  - PUSH at full -> overflow;
  - DUP at full -> overflow;
  - POP at empty -> underflow;
  - SELECT with 1 or 2 entries -> underflow;
  - count reaching capacity sets full, with no wrap-around of the index;
  - POP reaching 0 sets empty and top=0.

Test Plan:
- Reset, then push 1, push 2, push 0, SELECT:
  - top=2, count=1, empty=0, trap=0 at most 4 cycles after the first op;
  - repeat with condition 7: top=1.
- SELECT with condition 64'h1_0000_0000 and COND_WIDTH=32 -> upper bits ignored, so the b operand is chosen: push 5, push 9 -> top=9.
- Push 2**DEPTH_LOG2 values (16 for the default): full=1, count=16. A further push -> trap=2, ready=0, top and count unchanged.
- From reset, POP -> trap=1, pop_valid stays 0. Further ops are ignored. Assert reset -> trap=0, ready=1, empty=1.
- Push 10, 20; DUP; POP; POP:
  - pop_data 20 with pop_valid pulse, then 20 again;
  - top=10, count=1.
- Op code 6 -> trap=3. Assert reset in the same cycle as a PUSH -> count=0 and no push applied.
